osd_mam_engine: RTL and testbench

//  Memory-access engine for the MAM debug module. Runs behind the register-access layer.

---
 rtl/osd_mam_engine.sv | 365 ++++++++++++++++++++++++++++++++++++
 tb/tb_osd_mam_engine.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_mam_engine.sv
`default_nettype none
// ============================================================================
//  Module   : osd_mam_engine
//  Purpose  : Memory-access engine for the MAM debug module. Decodes command
//             packets from the debug interconnect into memory requests,
//             streams write data from continuation packets into memory beats,
//             and returns read data as response packets of at most
//             MAX_PKT_LEN flits.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//   clk, rst                       clock, synchronous active-high reset
//   id[15:0]                       own interconnect address (src of replies)
//   in_data/valid/last, in_ready   incoming flit stream
//   out_data/valid/last, out_ready response flit stream
//   req_valid/ready, req_rw, req_addr, req_burst, req_size
//                                  memory request channel
//   write_valid/ready, write_data, write_strb
//                                  write data channel
//   read_valid/ready, read_data    read data channel
//   busy                           engine is not idle
// ============================================================================
module osd_mam_engine #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MAX_PKT_LEN = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [15:0]             id,
    input  logic [15:0]             in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [15:0]             out_data,
    output logic                    out_valid,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic                    req_rw,
    output logic [ADDR_WIDTH-1:0]   req_addr,
    output logic                    req_burst,
    output logic [13:0]             req_size,
    output logic                    write_valid,
    input  logic                    write_ready,
    output logic [DATA_WIDTH-1:0]   write_data,
    output logic [DATA_WIDTH/8-1:0] write_strb,
    input  logic                    read_valid,
    output logic                    read_ready,
    input  logic [DATA_WIDTH-1:0]   read_data,
    output logic                    busy
);

    localparam int C_W  = DATA_WIDTH / 16;           // flits per word
    localparam int C_A  = ADDR_WIDTH / 16;           // address flits
    localparam int C_P  = (MAX_PKT_LEN - 3) / C_W;   // words per response packet
    localparam int C_CW = $clog2(MAX_PKT_LEN + 1);
    localparam int C_SW = DATA_WIDTH / 8;

    localparam logic [C_CW-1:0] C_W_LAST = C_CW'(C_W - 1);
    localparam logic [C_CW-1:0] C_A_LAST = C_CW'(C_A - 1);
    localparam logic [C_CW-1:0] C_P_LAST = C_CW'(C_P - 1);
    localparam logic [C_CW-1:0] C_HDR_LAST = C_CW'(2);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_HDR   = 4'd1,
        S_CMD   = 4'd2,
        S_ADDR  = 4'd3,
        S_STRB  = 4'd4,
        S_DROP  = 4'd5,
        S_REQ   = 4'd6,
        S_WHDR  = 4'd7,
        S_WDATA = 4'd8,
        S_WWAIT = 4'd9,
        S_RWAIT = 4'd10,
        S_RHDR  = 4'd11,
        S_RDATA = 4'd12
    } state_t;

    state_t                  state_q, state_d, ret_q, ret_d;
    logic [C_CW-1:0]         cnt_q, cnt_d;           // header / address / out flit index
    logic [C_CW-1:0]         wcnt_q, wcnt_d;         // flits of current write word
    logic [C_CW-1:0]         pkt_words_q, pkt_words_d;
    logic [13:0]             words_q, words_d;       // words still to transfer
    logic [15:0]             src_q, src_d;
    logic [C_SW-1:0]         strb_q, strb_d;
    logic                    tail_q, tail_d;         // command packet has trailing flits
    logic                    pkt_end_q, pkt_end_d;   // last write word closed its packet
    logic [DATA_WIDTH-1:0]   wbuf_q, wbuf_d;
    logic [DATA_WIDTH-1:0]   rshift_q, rshift_d;
    logic                    in_ready_q, in_ready_d;
    logic [15:0]             out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic                    req_valid_q, req_valid_d;
    logic                    req_rw_q, req_rw_d;
    logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic                    req_burst_q, req_burst_d;
    logic [13:0]             req_size_q, req_size_d;
    logic                    write_valid_q, write_valid_d;
    logic [DATA_WIDTH-1:0]   write_data_q, write_data_d;
    logic [C_SW-1:0]         write_strb_q, write_strb_d;
    logic                    read_ready_q, read_ready_d;
    logic                    busy_q, busy_d;

    logic w_in_fire, w_out_fire, w_word_last, w_cmd_done, w_cmd_tail;

    assign w_in_fire   = in_valid & in_ready_q;
    assign w_out_fire  = out_valid_q & out_ready;
    // Current read word closes the response packet.
    assign w_word_last = (words_q == 14'd1) || (pkt_words_q == C_P_LAST);

    always_comb begin
        state_d       = state_q;
        ret_d         = ret_q;
        cnt_d         = cnt_q;
        wcnt_d        = wcnt_q;
        pkt_words_d   = pkt_words_q;
        words_d       = words_q;
        src_d         = src_q;
        strb_d        = strb_q;
        tail_d        = tail_q;
        pkt_end_d     = pkt_end_q;
        wbuf_d        = wbuf_q;
        rshift_d      = rshift_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        req_rw_d      = req_rw_q;
        req_addr_d    = req_addr_q;
        req_burst_d   = req_burst_q;
        req_size_d    = req_size_q;
        write_data_d  = write_data_q;
        write_strb_d  = write_strb_q;
        w_cmd_done    = 1'b0;
        w_cmd_tail    = 1'b0;

        case (state_q)
            S_IDLE: if (w_in_fire) begin
                cnt_d = '0;
                if (!in_last) state_d = S_HDR;
            end
            S_HDR: if (w_in_fire) begin
                if (cnt_q == '0) src_d = in_data;
                if (in_last)                 state_d = S_IDLE;
                else if (cnt_q == C_CW'(1))  state_d = S_CMD;
                else                         cnt_d = cnt_q + C_CW'(1);
            end
            S_CMD: if (w_in_fire) begin
                req_rw_d    = in_data[15];
                req_burst_d = in_data[14];
                req_size_d  = in_data[14] ? in_data[13:0] : 14'd1;
                cnt_d       = '0;
                state_d     = in_last ? S_IDLE : S_ADDR;
            end
            S_ADDR: if (w_in_fire) begin
                // Least-significant flit arrives first: shift in from the top.
                req_addr_d = ADDR_WIDTH'({in_data, req_addr_q} >> 16);
                if (cnt_q != C_A_LAST) begin
                    cnt_d = cnt_q + C_CW'(1);
                    if (in_last) state_d = S_IDLE;
                end else if (req_rw_q && !req_burst_q) begin
                    state_d = in_last ? S_IDLE : S_STRB;
                end else begin
                    w_cmd_done = 1'b1;
                    w_cmd_tail = ~in_last;
                end
            end
            S_STRB: if (w_in_fire) begin
                strb_d     = in_data[C_SW-1:0];
                w_cmd_done = 1'b1;
                w_cmd_tail = ~in_last;
            end
            S_DROP: if (w_in_fire && in_last) begin
                state_d = ret_q;
            end
            S_REQ: if (req_valid_q && req_ready) begin
                cnt_d       = '0;
                wcnt_d      = '0;
                pkt_words_d = '0;
                ret_d       = req_rw_q ? S_WHDR : S_RWAIT;
                // Trailing command flits are flushed before the data phase.
                if (tail_q)        state_d = S_DROP;
                else if (req_rw_q) state_d = S_WHDR;
                else               state_d = S_RWAIT;
            end
            S_WHDR: if (w_in_fire) begin
                if (in_last) begin
                    cnt_d = '0;
                end else if (cnt_q == C_HDR_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WDATA;
                end else begin
                    cnt_d = cnt_q + C_CW'(1);
                end
            end
            S_WDATA: if (w_in_fire) begin
                wbuf_d = DATA_WIDTH'({wbuf_q, in_data});
                if (wcnt_q == C_W_LAST) begin
                    wcnt_d       = '0;
                    write_data_d = DATA_WIDTH'({wbuf_q, in_data});
                    write_strb_d = req_burst_q ? {C_SW{1'b1}} : strb_q;
                    pkt_end_d    = in_last;
                    state_d      = S_WWAIT;
                end else begin
                    // A partial word survives into the next data packet.
                    wcnt_d = wcnt_q + C_CW'(1);
                    if (in_last) state_d = S_WHDR;
                end
            end
            S_WWAIT: if (write_valid_q && write_ready) begin
                words_d = words_q - 14'd1;
                if (words_q == 14'd1) begin
                    ret_d   = S_IDLE;
                    state_d = pkt_end_q ? S_IDLE : S_DROP;
                end else begin
                    state_d = pkt_end_q ? S_WHDR : S_WDATA;
                end
            end
            S_RWAIT: if (read_ready_q && read_valid) begin
                out_valid_d = 1'b1;
                cnt_d       = '0;
                if (pkt_words_q == '0) begin
                    out_data_d = src_q;
                    out_last_d = 1'b0;
                    rshift_d   = read_data;
                    state_d    = S_RHDR;
                end else begin
                    out_data_d = read_data[DATA_WIDTH-1 -: 16];
                    out_last_d = (C_W == 1) && w_word_last;
                    rshift_d   = read_data << 16;
                    state_d    = S_RDATA;
                end
            end
            S_RHDR: if (w_out_fire) begin
                if (cnt_q == C_HDR_LAST) begin
                    out_data_d = rshift_q[DATA_WIDTH-1 -: 16];
                    out_last_d = (C_W == 1) && w_word_last;
                    rshift_d   = rshift_q << 16;
                    cnt_d      = '0;
                    state_d    = S_RDATA;
                end else begin
                    out_data_d = (cnt_q == '0) ? id : 16'h0000;
                    cnt_d      = cnt_q + C_CW'(1);
                end
            end
            S_RDATA: if (w_out_fire) begin
                if (cnt_q == C_W_LAST) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    words_d     = words_q - 14'd1;
                    if (words_q == 14'd1) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d     = S_RWAIT;
                        pkt_words_d = (pkt_words_q == C_P_LAST) ? '0 : pkt_words_q + C_CW'(1);
                    end
                end else begin
                    out_data_d = rshift_q[DATA_WIDTH-1 -: 16];
                    out_last_d = ((cnt_q + C_CW'(1)) == C_W_LAST) && w_word_last;
                    rshift_d   = rshift_q << 16;
                    cnt_d      = cnt_q + C_CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_cmd_done) begin
            words_d = req_size_q;
            tail_d  = w_cmd_tail;
            if (req_burst_q && (req_size_q == 14'd0)) begin
                ret_d   = S_IDLE;
                state_d = w_cmd_tail ? S_DROP : S_IDLE;
            end else begin
                state_d = S_REQ;
            end
        end

        // Handshake outputs are registered decodes of the next state.
        in_ready_d    = (state_d == S_IDLE) || (state_d == S_HDR)  || (state_d == S_CMD) ||
                        (state_d == S_ADDR) || (state_d == S_STRB) || (state_d == S_DROP) ||
                        (state_d == S_WHDR) || (state_d == S_WDATA);
        req_valid_d   = (state_d == S_REQ);
        write_valid_d = (state_d == S_WWAIT);
        read_ready_d  = (state_d == S_RWAIT);
        busy_d        = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ret_q         <= S_IDLE;
            cnt_q         <= '0;
            wcnt_q        <= '0;
            pkt_words_q   <= '0;
            words_q       <= '0;
            src_q         <= '0;
            strb_q        <= '0;
            tail_q        <= 1'b0;
            pkt_end_q     <= 1'b0;
            wbuf_q        <= '0;
            rshift_q      <= '0;
            in_ready_q    <= 1'b0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            req_valid_q   <= 1'b0;
            req_rw_q      <= 1'b0;
            req_addr_q    <= '0;
            req_burst_q   <= 1'b0;
            req_size_q    <= '0;
            write_valid_q <= 1'b0;
            write_data_q  <= '0;
            write_strb_q  <= '0;
            read_ready_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ret_q         <= ret_d;
            cnt_q         <= cnt_d;
            wcnt_q        <= wcnt_d;
            pkt_words_q   <= pkt_words_d;
            words_q       <= words_d;
            src_q         <= src_d;
            strb_q        <= strb_d;
            tail_q        <= tail_d;
            pkt_end_q     <= pkt_end_d;
            wbuf_q        <= wbuf_d;
            rshift_q      <= rshift_d;
            in_ready_q    <= in_ready_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            req_valid_q   <= req_valid_d;
            req_rw_q      <= req_rw_d;
            req_addr_q    <= req_addr_d;
            req_burst_q   <= req_burst_d;
            req_size_q    <= req_size_d;
            write_valid_q <= write_valid_d;
            write_data_q  <= write_data_d;
            write_strb_q  <= write_strb_d;
            read_ready_q  <= read_ready_d;
            busy_q        <= busy_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign req_valid   = req_valid_q;
    assign req_rw      = req_rw_q;
    assign req_addr    = req_addr_q;
    assign req_burst   = req_burst_q;
    assign req_size    = req_size_q;
    assign write_valid = write_valid_q;
    assign write_data  = write_data_q;
    assign write_strb  = write_strb_q;
    assign read_ready  = read_ready_q;
    assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_osd_mam_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_osd_mam_engine
//  Purpose  : Scoreboard bench for osd_mam_engine (DATA_WIDTH=32,
//             ADDR_WIDTH=32, MAX_PKT_LEN=8). Directed packets push expected
//             requests, write beats and response flits into queues; a monitor
//             pops and compares on every completed handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_osd_mam_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] id  = 16'h0009;
    logic [15:0] in_data;
    logic        in_valid, in_last, in_ready;
    logic [15:0] out_data;
    logic        out_valid, out_last, out_ready;
    logic        req_valid, req_ready, req_rw, req_burst;
    logic [31:0] req_addr;
    logic [13:0] req_size;
    logic        write_valid, write_ready;
    logic [31:0] write_data;
    logic [3:0]  write_strb;
    logic        read_valid, read_ready;
    logic [31:0] read_data;
    logic        busy;

    always #5 clk = ~clk;

    osd_mam_engine #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_PKT_LEN(8)) dut (
        .clk(clk), .rst(rst), .id(id),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_addr(req_addr),
        .req_burst(req_burst), .req_size(req_size),
        .write_valid(write_valid), .write_ready(write_ready), .write_data(write_data),
        .write_strb(write_strb),
        .read_valid(read_valid), .read_ready(read_ready), .read_data(read_data),
        .busy(busy)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [47:0] exp_req[$];   // {rw, burst, size, addr}
    logic [35:0] exp_wr[$];    // {strb, data}
    logic [16:0] exp_out[$];   // {last, data}
    logic [31:0] mem_q[$];
    logic [15:0] tx_q[$];
    bit          out_toggle = 1'b0;
    bit          rd_fire_n  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rst_check(input string name);
        check({name, "_ctl"}, 64'({req_valid, write_valid, read_ready, out_valid, out_last, in_ready, busy}), 64'd0);
        check({name, "_req"}, 64'({req_rw, req_burst, req_size, req_addr}), 64'd0);
        check({name, "_wr"},  64'({write_strb, write_data}), 64'd0);
    endtask

    // Monitor: handshakes complete at the posedge following a negedge that sees valid&ready.
    initial begin : monitor
        logic        pw_stall, po_stall;
        logic [35:0] pw;
        logic [16:0] po;
        logic [47:0] er;
        logic [35:0] ew;
        logic [16:0] eo;
        pw_stall = 1'b0; po_stall = 1'b0; pw = '0; po = '0;
        forever begin
            @(negedge clk);
            rd_fire_n = read_valid && read_ready;
            if (rst) begin
                pw_stall = 1'b0;
                po_stall = 1'b0;
            end else begin
                if (pw_stall) begin
                    check("wr_hold_valid", 64'(write_valid), 64'd1);
                    check("wr_hold_data", 64'({write_strb, write_data}), 64'(pw));
                end
                if (po_stall) check("out_hold", 64'({out_valid, out_last, out_data}), 64'({1'b1, po}));
                if (req_valid && req_ready) begin
                    if (exp_req.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_req: got %0h expected none", {req_rw, req_burst, req_size, req_addr});
                    end else begin
                        er = exp_req.pop_front();
                        check("req", 64'({req_rw, req_burst, req_size, req_addr}), 64'(er));
                    end
                end
                if (write_valid && write_ready) begin
                    if (exp_wr.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_write: got %0h expected none", {write_strb, write_data});
                    end else begin
                        ew = exp_wr.pop_front();
                        check("write_beat", 64'({write_strb, write_data}), 64'(ew));
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_out.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_flit: got %0h expected none", {out_last, out_data});
                    end else begin
                        eo = exp_out.pop_front();
                        check("out_flit", 64'({out_last, out_data}), 64'(eo));
                    end
                end
                pw_stall = write_valid && !write_ready;
                pw       = {write_strb, write_data};
                if (pw_stall) check("wwait_in_ready", 64'(in_ready), 64'd0);
                po_stall = out_valid && !out_ready;
                po       = {out_last, out_data};
            end
        end
    end

    // Memory read responder and response-stream ready driver.
    initial begin : responder
        read_valid = 1'b0; read_data = '0; out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rd_fire_n && mem_q.size() != 0) mem_q.delete(0);
            read_valid = !rst && (mem_q.size() != 0);
            read_data  = (mem_q.size() != 0) ? mem_q[0] : 32'h0;
            out_ready  = out_toggle ? !out_ready : 1'b1;
        end
    end

    task automatic send_tx();
        int t;
        for (int i = 0; i < tx_q.size(); i++) begin
            in_data  = tx_q[i];
            in_valid = 1'b1;
            in_last  = (i == tx_q.size() - 1);
            t = 0;
            while (t <= 300) begin
                @(negedge clk);
                if (in_ready) break;
                t++;
            end
            if (t > 300) begin
                n_cmp++; n_bad++;
                $display("FAIL in_accept_timeout: flit %0d got no in_ready expected acceptance", i);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        tx_q.delete();
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        repeat (10) @(negedge clk);
        while (t < 400 && (busy || exp_req.size() != 0 || exp_wr.size() != 0 || exp_out.size() != 0)) begin
            @(negedge clk);
            t++;
        end
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_left"}, 64'(exp_req.size() + exp_wr.size() + exp_out.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic exp_hdr();
        exp_out.push_back({1'b0, 16'h0005});
        exp_out.push_back({1'b0, 16'h0009});
        exp_out.push_back({1'b0, 16'h0000});
    endtask

    initial begin : stimulus
        int t;
        in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        req_ready = 1'b1; write_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_check("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Burst read of 3 words split into 2+1 word response packets, out_ready toggling.
        out_toggle = 1'b1;
        mem_q = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
        exp_req.push_back({1'b0, 1'b1, 14'd3, 32'h1000_0040});
        exp_hdr();
        exp_out.push_back({1'b0, 16'h1111}); exp_out.push_back({1'b0, 16'h2222});
        exp_out.push_back({1'b0, 16'h3333}); exp_out.push_back({1'b1, 16'h4444});
        exp_hdr();
        exp_out.push_back({1'b0, 16'h5555}); exp_out.push_back({1'b1, 16'h6666});
        tx_q = '{16'h0009, 16'h0005, 16'h0000, 16'h4003, 16'h0040, 16'h1000};
        send_tx();
        drain("burst_read");
        out_toggle = 1'b0;

        // Single write with strobe, write_ready held low for 5 cycles.
        write_ready = 1'b0;
        exp_req.push_back({1'b1, 1'b0, 14'd1, 32'h0000_0010});
        exp_wr.push_back({4'b0011, 32'hDEAD_BEEF});
        tx_q = '{16'h0009, 16'h0005, 16'h0000, 16'h8000, 16'h0010, 16'h0000, 16'h0003};
        send_tx();
        tx_q = '{16'h0009, 16'h0005, 16'h1234, 16'hDEAD, 16'hBEEF};
        send_tx();
        t = 0;
        while (t < 50 && !write_valid) begin @(posedge clk); #1; t++; end
        repeat (5) begin @(posedge clk); #1; end
        @(negedge clk);
        check("wr_stall_valid", 64'(write_valid), 64'd1);
        check("wr_stall_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        write_ready = 1'b1;
        drain("single_write");

        // Burst write of 2 words, second word split across two data packets.
        exp_req.push_back({1'b1, 1'b1, 14'd2, 32'h2000_0000});
        exp_wr.push_back({4'hF, 32'hAAAA_BBBB});
        exp_wr.push_back({4'hF, 32'hCCCC_DDDD});
        tx_q = '{16'h0009, 16'h0005, 16'h0000, 16'hC002, 16'h0000, 16'h2000};
        send_tx();
        tx_q = '{16'h0009, 16'h0005, 16'h0000, 16'hAAAA, 16'hBBBB, 16'hCCCC};
        send_tx();
        tx_q = '{16'h0009, 16'h0005, 16'h0000, 16'hDDDD};
        send_tx();
        drain("burst_write");

        // Command packet ending after one address flit: discarded.
        tx_q = '{16'h0009, 16'h0005, 16'h0000, 16'h4002, 16'h1234};
        send_tx();
        drain("short_cmd");

        // Burst with size 0: consumed, no request.
        tx_q = '{16'h0009, 16'h0005, 16'h0000, 16'h4000, 16'h5678, 16'h0000};
        send_tx();
        drain("burst_size0");

        // Single read with a nonzero size field (forced to 1) and trailing flits.
        mem_q = '{32'hCAFE_F00D};
        exp_req.push_back({1'b0, 1'b0, 14'd1, 32'h0000_0080});
        exp_hdr();
        exp_out.push_back({1'b0, 16'hCAFE}); exp_out.push_back({1'b1, 16'hF00D});
        tx_q = '{16'h0009, 16'h0005, 16'h0000, 16'h0005, 16'h0080, 16'h0000, 16'hEEEE, 16'hFFFF};
        send_tx();
        drain("single_read_tail");

        // Reset in the middle of a 3-word read after the first word.
        mem_q = '{32'hA1A1_B2B2};
        exp_req.push_back({1'b0, 1'b1, 14'd3, 32'h0000_0300});
        exp_hdr();
        exp_out.push_back({1'b0, 16'hA1A1}); exp_out.push_back({1'b0, 16'hB2B2});
        tx_q = '{16'h0009, 16'h0005, 16'h0000, 16'h4003, 16'h0300, 16'h0000};
        send_tx();
        t = 0;
        while (t < 200 && exp_out.size() != 0) begin @(posedge clk); #1; t++; end
        check("pre_reset_left", 64'(exp_out.size() + exp_req.size()), 64'd0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_check("mid_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        mem_q.delete();
        exp_out.delete();
        @(posedge clk); #1;

        // Normal command after the aborted one.
        mem_q = '{32'h0102_0304};
        exp_req.push_back({1'b0, 1'b0, 14'd1, 32'h0000_0400});
        exp_hdr();
        exp_out.push_back({1'b0, 16'h0102}); exp_out.push_back({1'b1, 16'h0304});
        tx_q = '{16'h0009, 16'h0005, 16'h0000, 16'h0000, 16'h0400, 16'h0000};
        send_tx();
        drain("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
